// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   WIDTH_*     : access-width encodings carried on the width ports
//   CNT_W       : width of the fetch starvation counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_INST = 2'd1,
        BUSY_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data load/store.
// One transaction outstanding at a time; data wins by default, but after STARVE_LIMIT
// consecutive data grants with fetch waiting, the next grant goes to fetch.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_inst_req/i_inst_addr         fetch request (level) and address
//   o_inst_rdata/o_inst_valid      fetched word and one-cycle completion pulse
//   o_inst_stall                   fetch waiting (req & ~valid)
//   i_data_req/we/addr/wdata/
//   i_data_width/i_data_zeroextend data request and its fields
//   o_data_rdata/o_data_valid      load result (0 for stores) and completion pulse
//   o_data_stall                   data waiting (req & ~valid)
//   o_mem_*                        registered request towards the memory controller
//   i_mem_ack/i_mem_rdata          completion and read data from memory
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_inst_req,
    input  logic [ADDR_W-1:0] i_inst_addr,
    output logic [DATA_W-1:0] o_inst_rdata,
    output logic              o_inst_valid,
    output logic              o_inst_stall,

    input  logic              i_data_req,
    input  logic              i_data_we,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wdata,
    input  logic [1:0]        i_data_width,
    input  logic              i_data_zeroextend,
    output logic [DATA_W-1:0] o_data_rdata,
    output logic              o_data_valid,
    output logic              o_data_stall,

    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [1:0]        o_mem_width,
    output logic              o_mem_zeroextend,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_width_q, mem_width_d;
    logic              mem_zext_q, mem_zext_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic              inst_valid_q, inst_valid_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              data_valid_q, data_valid_d;

    logic force_inst;
    logic grant_inst;
    logic grant_data;

    // Fetch has sat through STARVE_LIMIT data grants: it must win this evaluation.
    assign force_inst = i_inst_req & (cnt_q == LIMIT_C);
    assign grant_inst = (state_q == IDLE) & (force_inst | (i_inst_req & ~i_data_req));
    assign grant_data = (state_q == IDLE) & ~force_inst & i_data_req;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_width_d  = mem_width_q;
        mem_zext_d   = mem_zext_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_valid_d = 1'b0;
        data_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // i_mem_ack is deliberately ignored here.
                if (grant_inst) begin
                    state_d     = BUSY_INST;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_inst_addr;
                    mem_wdata_d = '0;
                    mem_width_d = WIDTH_WORD;
                    mem_zext_d  = 1'b0;
                end else if (grant_data) begin
                    state_d     = BUSY_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = i_data_we;
                    mem_addr_d  = i_data_addr;
                    mem_wdata_d = i_data_wdata;
                    mem_width_d = i_data_width;
                    mem_zext_d  = i_data_zeroextend;
                    // Count only grants that actually made fetch wait; saturate at the limit.
                    if (i_inst_req) begin
                        if (cnt_q != LIMIT_C) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            BUSY_INST: begin
                if (i_mem_ack) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    inst_rdata_d = i_mem_rdata;
                    inst_valid_d = 1'b1;
                end
            end
            BUSY_DATA: begin
                if (i_mem_ack) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    data_rdata_d = mem_we_q ? '0 : i_mem_rdata;
                    data_valid_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_width_q  <= '0;
            mem_zext_q   <= 1'b0;
            inst_rdata_q <= '0;
            inst_valid_q <= 1'b0;
            data_rdata_q <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_width_q  <= mem_width_d;
            mem_zext_q   <= mem_zext_d;
            inst_rdata_q <= inst_rdata_d;
            inst_valid_q <= inst_valid_d;
            data_rdata_q <= data_rdata_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign o_mem_req        = mem_req_q;
    assign o_mem_we         = mem_we_q;
    assign o_mem_addr       = mem_addr_q;
    assign o_mem_wdata      = mem_wdata_q;
    assign o_mem_width      = mem_width_q;
    assign o_mem_zeroextend = mem_zext_q;
    assign o_inst_rdata     = inst_rdata_q;
    assign o_inst_valid     = inst_valid_q;
    assign o_data_rdata     = data_rdata_q;
    assign o_data_valid     = data_valid_q;
    assign o_inst_stall     = i_inst_req & ~inst_valid_q;
    assign o_data_stall     = i_data_req & ~data_valid_q;

endmodule
